// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Registers are also driven out as a flat bus, with a pulse on each committed write.
module axi_lite_reg_slave #(
    parameter int NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [31:0]                 s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [31:0]                 s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic [32*NUM_REGS-1:0]      reg_q,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_index
);
    localparam int          IW     = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN   = 32'(4 * NUM_REGS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   regs_d [NUM_REGS];
    logic          aw_held_q, aw_held_d;
    logic          aw_ok_q, aw_ok_d;
    logic [IW-1:0] aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [31:0]   w_data_q, w_data_d;
    logic [3:0]    w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [IW-1:0] wr_index_q, wr_index_d;

    logic          aw_fire, w_fire, ar_fire, commit, ar_ok;
    logic [IW-1:0] ar_idx;
    logic          unused_prot;

    assign unused_prot   = ^{s_axi_awprot, s_axi_arprot};

    assign s_axi_awready = reset & ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = reset & ~w_held_q & ~bvalid_q;
    assign s_axi_arready = reset & ~rvalid_q;

    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;
    assign ar_fire = s_axi_arvalid & s_axi_arready;
    assign commit  = aw_held_q & w_held_q;
    assign ar_ok   = s_axi_araddr < SPAN;
    assign ar_idx  = s_axi_araddr[IW+1:2];

    always_comb begin
        regs_d     = regs_q;
        aw_held_d  = aw_held_q;
        aw_ok_d    = aw_ok_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        wr_pulse_d = 1'b0;
        wr_index_d = wr_index_q;

        if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_ok_d   = s_axi_awaddr < SPAN;
            aw_idx_d  = s_axi_awaddr[IW+1:2];
        end
        if (w_fire) begin
            w_held_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        if (bvalid_q & s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        // Readies are gated by the held flags and bvalid, so commit never overlaps a B handshake.
        if (commit) begin
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = aw_ok_q ? OKAY : SLVERR;
            wr_pulse_d = aw_ok_q;
            wr_index_d = aw_idx_q;
            if (aw_ok_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[aw_idx_q][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end

        // Read samples regs_q, so a same-edge write commit is not visible here.
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_ok ? regs_q[ar_idx] : 32'h0;
            rresp_d  = ar_ok ? OKAY : SLVERR;
        end else if (rvalid_q & s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q     <= '{default: '0};
            aw_held_q  <= 1'b0;
            aw_ok_q    <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
        end else begin
            regs_q     <= regs_d;
            aw_held_q  <= aw_held_d;
            aw_ok_q    <= aw_ok_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign reg_q[32*gi +: 32] = regs_q[gi];
        end
    endgenerate

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign wr_pulse     = wr_pulse_q;
    assign wr_index     = wr_index_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed and randomized checks of axi_lite_reg_slave against an array-based register model.
module tb_axi_lite_reg_slave;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_axi_awvalid, s_axi_awready;
    logic [31:0]   s_axi_awaddr;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_wvalid, s_axi_wready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_bvalid, s_axi_bready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [31:0]   s_axi_araddr;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_rvalid, s_axi_rready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic [32*N-1:0] reg_q;
    logic          wr_pulse;
    logic [$clog2(N)-1:0] wr_index;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [N];

    always #5 clk = ~clk;

    axi_lite_reg_slave #(.NUM_REGS(N)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_index(wr_index)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [31:0] addr);
        return addr < 32'(4 * N);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % N);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], model[i]);
    endtask

    // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int skew);
        int  aw_start, w_start, cyc;
        bit  aw_done, w_done, aw_f, w_f;
        aw_start = (skew < 0) ? -skew : 0;
        w_start  = (skew > 0) ? skew : 0;
        cyc = 0; aw_done = 0; w_done = 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_start);
            s_axi_wvalid  = !w_done && (cyc >= w_start);
            @(negedge clk);
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            tick();
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            cyc++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        chk({tag, "_handshake"}, 32'(aw_done && w_done), 32'd1);
        chk({tag, "_bvalid_pre"}, 32'(s_axi_bvalid), 32'd0);
        tick();
        chk({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(s_axi_bresp), in_range(addr) ? 32'd0 : 32'd2);
        chk({tag, "_wr_pulse"}, 32'(wr_pulse), 32'(in_range(addr)));
        if (in_range(addr)) begin
            chk({tag, "_wr_index"}, 32'(wr_index), 32'(word_of(addr)));
            model[word_of(addr)] = merge(model[word_of(addr)], data, strb);
            chk({tag, "_reg"}, reg_q[32*word_of(addr) +: 32], model[word_of(addr)]);
        end
        tick();
        chk({tag, "_bvalid_clr"}, 32'(s_axi_bvalid), 32'd0);
        chk({tag, "_wr_pulse_clr"}, 32'(wr_pulse), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr);
        int cyc;
        bit f;
        logic [31:0] exp_data;
        s_axi_araddr = addr; s_axi_arvalid = 1;
        cyc = 0; f = 0;
        while (!f && cyc < 40) begin
            @(negedge clk);
            f = s_axi_arready;
            tick();
            cyc++;
        end
        s_axi_arvalid = 0;
        exp_data = in_range(addr) ? model[word_of(addr)] : 32'h0;
        chk({tag, "_ar_handshake"}, 32'(f), 32'd1);
        chk({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
        chk({tag, "_rdata"}, s_axi_rdata, exp_data);
        chk({tag, "_rresp"}, 32'(s_axi_rresp), in_range(addr) ? 32'd0 : 32'd2);
        tick();
        chk({tag, "_rvalid_clr"}, 32'(s_axi_rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] old_val, new_val, addr;
        reset = 0;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awprot = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arprot = 0;
        s_axi_bready = 1; s_axi_rready = 1;
        for (int i = 0; i < N; i++) model[i] = 32'h0;

        // Reset held low for three cycles with readies forced low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_awready", 32'(s_axi_awready), 32'd0);
            chk("rst_wready", 32'(s_axi_wready), 32'd0);
            chk("rst_arready", 32'(s_axi_arready), 32'd0);
            tick();
        end
        reset = 1;
        #1;
        chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("post_rst_wready", 32'(s_axi_wready), 32'd1);
        chk("post_rst_arready", 32'(s_axi_arready), 32'd1);
        chk("post_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("post_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("post_rst_wr_pulse", 32'(wr_pulse), 32'd0);
        check_all_regs("post_rst");
        for (int i = 0; i < N; i++) do_read($sformatf("rd_rst%0d", i), 32'(4 * i));

        // Simultaneous AW+W, then W-first partial strobe.
        do_write("wr_sim", 32'h08, 32'hDEADBEEF, 4'hF, 0);
        do_read("rd_sim", 32'h08);
        do_write("wr_wfirst", 32'h08, 32'h11223344, 4'b0101, -3);
        chk("wfirst_const", reg_q[32*2 +: 32], 32'hDE22BE44);
        do_write("wr_awfirst", 32'h10, 32'hCAFEF00D, 4'b1010, 2);

        // Out of range and zero-strobe writes.
        do_write("wr_oor", 32'h40, 32'h12345678, 4'hF, 0);
        check_all_regs("after_oor");
        do_read("rd_oor", 32'h40);
        do_write("wr_nostrb", 32'h08, 32'hFFFFFFFF, 4'h0, 0);
        chk("nostrb_const", reg_q[32*2 +: 32], 32'hDE22BE44);

        // Same-edge read and write of reg 1 under response backpressure.
        do_write("wr_pre1", 32'h04, 32'hA5A50001, 4'hF, 0);
        s_axi_bready = 0; s_axi_rready = 0;
        s_axi_awaddr = 32'h04; s_axi_wdata = 32'h5A5A1234; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clk);
        chk("bp_aw_ready", 32'(s_axi_awready && s_axi_wready), 32'd1);
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 32'h04; s_axi_arvalid = 1;
        @(negedge clk);
        chk("bp_ar_ready", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_arvalid = 0;
        old_val = model[1];
        new_val = 32'h5A5A1234;
        model[1] = new_val;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_bvalid_c%0d", c), 32'(s_axi_bvalid), 32'd1);
            chk($sformatf("bp_bresp_c%0d", c), 32'(s_axi_bresp), 32'd0);
            chk($sformatf("bp_rvalid_c%0d", c), 32'(s_axi_rvalid), 32'd1);
            chk($sformatf("bp_rdata_c%0d", c), s_axi_rdata, old_val);
            chk($sformatf("bp_awready_c%0d", c), 32'(s_axi_awready), 32'd0);
            chk($sformatf("bp_arready_c%0d", c), 32'(s_axi_arready), 32'd0);
            chk($sformatf("bp_reg1_c%0d", c), reg_q[32*1 +: 32], new_val);
            tick();
        end
        s_axi_bready = 1; s_axi_rready = 1;
        tick();
        chk("bp_bvalid_clr", 32'(s_axi_bvalid), 32'd0);
        chk("bp_rvalid_clr", 32'(s_axi_rvalid), 32'd0);
        chk("bp_awready_back", 32'(s_axi_awready), 32'd1);
        do_read("rd_bp_new", 32'h04);

        // Randomized mix of reads and writes with random skew.
        for (int t = 0; t < 40; t++) begin
            addr = 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write($sformatf("rnd_wr%0d", t), addr, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3);
            else
                do_read($sformatf("rnd_rd%0d", t), addr);
        end
        check_all_regs("after_rnd");

        // Reset while a write address is held and its data has not arrived.
        s_axi_awaddr = 32'h0C; s_axi_awvalid = 1;
        @(negedge clk);
        chk("mid_aw_ready", 32'(s_axi_awready), 32'd1);
        tick();
        s_axi_awvalid = 0;
        reset = 0;
        #1;
        chk("mid_rst_wready", 32'(s_axi_wready), 32'd0);
        tick();
        reset = 1;
        for (int i = 0; i < N; i++) model[i] = 32'h0;
        #1;
        chk("mid_awready", 32'(s_axi_awready), 32'd1);
        chk("mid_wready", 32'(s_axi_wready), 32'd1);
        chk("mid_arready", 32'(s_axi_arready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mid_bvalid_c%0d", c), 32'(s_axi_bvalid), 32'd0);
            chk($sformatf("mid_wr_pulse_c%0d", c), 32'(wr_pulse), 32'd0);
            tick();
        end
        check_all_regs("after_mid_rst");
        do_write("wr_final", 32'h3C, 32'h0BADF00D, 4'hF, 1);
        do_read("rd_final", 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
